potential_decay_array: RTL and testbench
========================================

POTENTIAL_DECAY_ARRAY -- requirements
Module: potential_decay_array

Interface
REQ-001 SHALL have parameter NEURON_COUNT, default 4, meaning the number of neurons in the bank (range 2..4096).
REQ-002 SHALL have parameter ADDR_W, default 12, meaning the neuron address width.
REQ-003 SHALL have port CLK, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port RESET_N, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port init_we / init_addr / init_potential / init_rate, input, 1 / ADDR_W / 32 / 4 bits: writes the initial FP32 potential and the decay code.
REQ-006 SHALL have port upd_we / upd_addr / upd_potential, input, 1 / ADDR_W / 32 bits: writes the potential from the potential adder.
REQ-007 SHALL have port start, input, 1 bit: a one-cycle timestep strobe.
REQ-008 SHALL have port busy, output, 1 bit: the timestep sweep is in progress.
REQ-009 SHALL have port done, output, 1 bit: a one-cycle pulse at the end of the sweep.
REQ-010 SHALL have port out_valid / out_ready, output / input, 1 bit each: the result stream handshake.
REQ-011 SHALL have port out_addr / out_potential, output, ADDR_W / 32 bits: the decayed neuron address and its value.
REQ-012 SHALL have port wr_drop, output, 1 bit: a one-cycle pulse when a write is discarded.

Function
REQ-013 SHALL hold per-neuron registers potential[32] and rate[4]; init writes both fields, upd writes potential only.
REQ-014 SHALL apply init over upd when both target the same address in the same cycle; both SHALL take effect for different addresses.
REQ-015 SHALL discard writes while busy=1, and any write with address >= NEURON_COUNT; each such cycle SHALL pulse wr_drop.
REQ-016 SHALL use FSM states IDLE, LOAD, COMPUTE, OUTPUT and DONE.
REQ-017 SHALL, on start in IDLE, set idx=0, assert busy and go to LOAD; start in any other state SHALL be ignored.
REQ-018 SHALL, in LOAD, register potential[idx] and rate[idx], then go to COMPUTE.
REQ-019 SHALL, in COMPUTE, register the decayed value, then go to OUTPUT with out_valid=1, out_addr=idx and out_potential set to the result.
REQ-020 SHALL, in OUTPUT, hold out_valid and its data stable until out_ready=1; on the handshake it SHALL write the result back to potential[idx], then go to LOAD with idx+1, or to DONE if idx=NEURON_COUNT-1.
REQ-021 SHALL, in DONE, pulse done for 1 cycle, deassert busy and return to IDLE.
REQ-022 SHALL produce the first out_valid 3 cycles after start; with out_ready held at 1, a sweep SHALL last 3*NEURON_COUNT+1 cycles.
REQ-023 SHALL decode the decay codes as follows: 0001 gives /1, 0010 gives /2, 0100 gives /4, 1000 gives /8, by exponent minus k where k=0..3, with sign and mantissa unchanged; any other code SHALL give /1.
REQ-024 SHALL, for code 0011 (x0.75), compute T = S + (S>>1), where S = {1, mantissa}, truncating; if T >= 2, exponent = e and mantissa = T[23:1]; otherwise exponent = e-1 and mantissa = T[22:0].
REQ-025 SHALL output signed zero when the input exponent = 0, or when the result exponent would be <= 0.
REQ-026 SHALL pass an input exponent of 255 (Inf/NaN) through unchanged.

Reset
REQ-027 SHALL, while RESET_N=0, asynchronously force FSM=IDLE, idx=0, busy=0, done=0, out_valid=0, out_addr=0, out_potential=0 and wr_drop=0.
REQ-028 SHALL reset every potential to 32'h00000000 and every rate to 4'b0001.
REQ-029 SHALL abort the sweep on a reset mid-sweep, with no write-back and no done pulse.

Configuration
REQ-030 SHALL, with macro POTENTIAL_DECAY_THREEQUARTER_EN defined, implement code 0011 per REQ-024.
REQ-031 SHALL, without POTENTIAL_DECAY_THREEQUARTER_EN, omit the REQ-024 logic and treat code 0011 as /1.

Verification
REQ-032 SHALL cover: init n0 = 41DED852 with rates 0001/0010/0100/1000 -> out_potential 41DED852/415ED852/40DED852/405ED852.
REQ-033 SHALL cover: init 41DED852 with rate 0011 and the macro on -> 41A7223D, with potential[n] updated; with the macro off -> 41DED852.
REQ-034 SHALL cover: init 01000000 with rate 0100, and 80000000 with rate 1000 -> 00000000 and 80000000; 7F800000 with rate 0010 -> 7F800000.
REQ-035 SHALL cover: NEURON_COUNT=4, start, with out_ready low for 5 cycles on n2 -> data on n2 held stable, addresses 0,1,2,3 in order, done one cycle after the last handshake.
REQ-036 SHALL cover: an upd write during busy, and a second start during busy -> wr_drop pulses, the bank is unchanged, and the sweep is unaffected; init+upd to the same address in the same cycle -> the init value is stored.
REQ-037 SHALL cover: RESET_N low while in OUTPUT on n1 -> out_valid=0 and busy=0 immediately, no done, and the bank returns to its reset values.

Source files
------------

// File: rtl/potential_decay_array.sv
// potential_decay_array: neuron potential bank with FP32 power-of-two decay sweep; define POTENTIAL_DECAY_THREEQUARTER_EN for the x0.75 code.
module potential_decay_array #(
    parameter int NEURON_COUNT = 4,
    parameter int ADDR_W       = 12
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              init_we,
    input  logic [ADDR_W-1:0] init_addr,
    input  logic [31:0]       init_potential,
    input  logic [3:0]        init_rate,
    input  logic              upd_we,
    input  logic [ADDR_W-1:0] upd_addr,
    input  logic [31:0]       upd_potential,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic [31:0]       out_potential,
    output logic              wr_drop
);
    localparam int IW = $clog2(NEURON_COUNT);
    localparam logic [ADDR_W:0]   LIM  = (ADDR_W+1)'(NEURON_COUNT);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NEURON_COUNT - 1);

    typedef enum logic [2:0] {IDLE, LOAD, COMPUTE, OUTPUT, DONE} state_t;

    state_t            state;
    logic [ADDR_W-1:0] idx;
    logic [31:0]       cur_pot;
    logic [3:0]        cur_rate;
    logic [31:0]       potential [NEURON_COUNT];
    logic [3:0]        rate      [NEURON_COUNT];
    logic              init_in, upd_in, init_ok, upd_ok, drop;

    function automatic logic [31:0] decay(input logic [31:0] x, input logic [3:0] code);
        logic [7:0] e;
        logic [7:0] k;
`ifdef POTENTIAL_DECAY_THREEQUARTER_EN
        logic [24:0] t;
`endif
        e = x[30:23];
        k = code == 4'b0010 ? 8'd1 : code == 4'b0100 ? 8'd2 : code == 4'b1000 ? 8'd3 : 8'd0;
        if (e == 8'd255)
            return x;
        if (e == 8'd0 || e <= k)
            return {x[31], 31'd0};
`ifdef POTENTIAL_DECAY_THREEQUARTER_EN
        if (code == 4'b0011) begin
            t = {2'b01, x[22:0]} + {3'b001, x[22:1]};
            if (t[24])
                return {x[31], e, t[23:1]};
            return e == 8'd1 ? {x[31], 31'd0} : {x[31], e - 8'd1, t[22:0]};
        end
`endif
        return {x[31], e - k, x[22:0]};
    endfunction

    // init wins a same-address collision; the losing upd is not counted as a drop
    assign init_in = {1'b0, init_addr} < LIM;
    assign upd_in  = {1'b0, upd_addr} < LIM;
    assign init_ok = init_we && !busy && init_in;
    assign upd_ok  = upd_we && !busy && upd_in && !(init_ok && init_addr == upd_addr);
    assign drop    = (init_we && (busy || !init_in)) || (upd_we && (busy || !upd_in));

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state         <= IDLE;
            idx           <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            out_valid     <= 1'b0;
            out_addr      <= '0;
            out_potential <= '0;
            wr_drop       <= 1'b0;
            cur_pot       <= '0;
            cur_rate      <= 4'b0001;
            for (int i = 0; i < NEURON_COUNT; i++) begin
                potential[i] <= '0;
                rate[i]      <= 4'b0001;
            end
        end else begin
            wr_drop <= drop;
            done    <= 1'b0;
            if (init_ok) begin
                potential[init_addr[IW-1:0]] <= init_potential;
                rate[init_addr[IW-1:0]]      <= init_rate;
            end
            if (upd_ok)
                potential[upd_addr[IW-1:0]] <= upd_potential;
            case (state)
                IDLE: if (start) begin
                    idx   <= '0;
                    busy  <= 1'b1;
                    state <= LOAD;
                end
                LOAD: begin
                    cur_pot  <= potential[idx[IW-1:0]];
                    cur_rate <= rate[idx[IW-1:0]];
                    state    <= COMPUTE;
                end
                COMPUTE: begin
                    out_valid     <= 1'b1;
                    out_addr      <= idx;
                    out_potential <= decay(cur_pot, cur_rate);
                    state         <= OUTPUT;
                end
                OUTPUT: if (out_ready) begin
                    out_valid               <= 1'b0;
                    potential[idx[IW-1:0]]  <= out_potential;
                    if (idx == LAST) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        idx   <= idx + 1'b1;
                        state <= LOAD;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_potential_decay_array.sv
// tb_potential_decay_array: directed sweeps with a scoreboard of expected outputs, checked on each handshake.
module tb_potential_decay_array;
    localparam int N = 4;
    localparam int AW = 12;
`ifdef POTENTIAL_DECAY_THREEQUARTER_EN
    localparam logic [31:0] E3Q1 = 32'h41A7223D;
    localparam logic [31:0] E3Q2 = 32'h417AB35B;
`else
    localparam logic [31:0] E3Q1 = 32'h41DED852;
    localparam logic [31:0] E3Q2 = 32'h41DED852;
`endif

    logic          CLK, RESET_N;
    logic          init_we, upd_we, start, out_ready;
    logic [AW-1:0] init_addr, upd_addr, out_addr;
    logic [31:0]   init_potential, upd_potential, out_potential;
    logic [3:0]    init_rate;
    logic          busy, done, out_valid, wr_drop;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [31:0]   p;
    } exp_t;
    exp_t q[$];
    int checks = 0;
    int errors = 0;

    potential_decay_array #(.NEURON_COUNT(N), .ADDR_W(AW)) dut (
        .CLK(CLK), .RESET_N(RESET_N),
        .init_we(init_we), .init_addr(init_addr), .init_potential(init_potential), .init_rate(init_rate),
        .upd_we(upd_we), .upd_addr(upd_addr), .upd_potential(upd_potential),
        .start(start), .busy(busy), .done(done),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_addr(out_addr), .out_potential(out_potential), .wr_drop(wr_drop)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic push(input int a, input logic [31:0] p);
        q.push_back({AW'(a), p});
    endtask

    always @(negedge CLK) begin
        if (RESET_N && out_valid && out_ready) begin
            check("sb_nonempty", 32'(q.size() != 0), 1);
            if (q.size() != 0) begin
                exp_t e;
                e = q.pop_front();
                check("sb_addr", 32'(out_addr), 32'(e.a));
                check("sb_data", out_potential, e.p);
            end
        end
    end

    task automatic wait_valid();
        int n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        check("wait_valid", 32'(out_valid), 1);
    endtask

    task automatic hs();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic init_w(input int a, input logic [31:0] p, input logic [3:0] r);
        init_we = 1'b1; init_addr = AW'(a); init_potential = p; init_rate = r;
        tick();
        init_we = 1'b0;
    endtask

    task automatic sweep_ready(input string tag);
        int nv = 0;
        int nd = 0;
        out_ready = 1'b1;
        start = 1'b1;
        for (int n = 1; n <= 100 && nd == 0; n++) begin
            tick();
            start = 1'b0;
            if (out_valid && nv == 0) nv = n;
            if (done) nd = n;
        end
        check({tag, "_first_valid"}, 32'(nv), 3);
        check({tag, "_done_cycle"}, 32'(nd), 3 * N + 1);
        tick();
        check({tag, "_busy_low"}, 32'(busy), 0);
        check({tag, "_done_low"}, 32'(done), 0);
        check({tag, "_sb_empty"}, 32'(q.size()), 0);
    endtask

    initial begin
        bit seen_done;
        RESET_N = 1'b0; init_we = 1'b0; upd_we = 1'b0; start = 1'b0; out_ready = 1'b1;
        init_addr = '0; upd_addr = '0; init_potential = '0; upd_potential = '0; init_rate = '0;
        #3;
        check("rst_busy", 32'(busy), 0);
        check("rst_valid", 32'(out_valid), 0);
        check("rst_done", 32'(done), 0);
        check("rst_drop", 32'(wr_drop), 0);
        check("rst_data", out_potential, 0);
        tick();
        tick();
        RESET_N = 1'b1;
        tick();

        // power-of-two decay codes
        init_w(0, 32'h41DED852, 4'b0001);
        init_w(1, 32'h41DED852, 4'b0010);
        init_w(2, 32'h41DED852, 4'b0100);
        init_w(3, 32'h41DED852, 4'b1000);
        check("init_nodrop", 32'(wr_drop), 0);
        push(0, 32'h41DED852); push(1, 32'h415ED852); push(2, 32'h40DED852); push(3, 32'h405ED852);
        sweep_ready("s1");

        // write-back decays again; stall on n2, dropped upd and ignored start while busy
        out_ready = 1'b0;
        push(0, 32'h41DED852); push(1, 32'h40DED852); push(2, 32'h3FDED852); push(3, 32'h3EDED852);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("s2_busy", 32'(busy), 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        upd_we = 1'b1; upd_addr = '0; upd_potential = 32'hDEADBEEF;
        tick();
        upd_we = 1'b0;
        check("busy_drop", 32'(wr_drop), 1);
        for (int k = 0; k < N; k++) begin
            wait_valid();
            check("order", 32'(out_addr), 32'(k));
            if (k == 2)
                for (int c = 0; c < 5; c++) begin
                    tick();
                    check("stall_valid", 32'(out_valid), 1);
                    check("stall_addr", 32'(out_addr), 2);
                    check("stall_data", out_potential, 32'h3FDED852);
                end
            hs();
        end
        check("s2_done", 32'(done), 1);
        tick();
        check("s2_done_pulse", 32'(done), 0);
        check("s2_busy_low", 32'(busy), 0);

        // x0.75 code, underflow, signed zero, init-over-upd collision, out-of-range drop
        init_w(1, 32'h41DED852, 4'b0011);
        init_w(2, 32'h01000000, 4'b0100);
        upd_we = 1'b1; upd_addr = AW'(3); upd_potential = 32'h12345678;
        init_w(3, 32'h80000000, 4'b1000);
        upd_we = 1'b0;
        check("collide_nodrop", 32'(wr_drop), 0);
        init_w(N, 32'h3F800000, 4'b0001);
        check("range_drop", 32'(wr_drop), 1);
        tick();
        check("drop_pulse", 32'(wr_drop), 0);
        push(0, 32'h41DED852); push(1, E3Q1); push(2, 32'h00000000); push(3, 32'h80000000);
        sweep_ready("s3");

        // Inf passthrough, zero exponent, init+upd on different addresses
        upd_we = 1'b1; upd_addr = AW'(2); upd_potential = 32'h42000000;
        init_w(0, 32'h7F800000, 4'b0010);
        upd_we = 1'b0;
        push(0, 32'h7F800000); push(1, E3Q2); push(2, 32'h41000000); push(3, 32'h80000000);
        sweep_ready("s4");

        // reset while presenting n1
        out_ready = 1'b0;
        push(0, 32'h7F800000);
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_valid();
        hs();
        wait_valid();
        check("rst_at_n1", 32'(out_addr), 1);
        RESET_N = 1'b0;
        #1;
        check("mid_rst_valid", 32'(out_valid), 0);
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_sb", 32'(q.size()), 0);
        q.delete();
        tick();
        RESET_N = 1'b1;
        seen_done = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            if (done) seen_done = 1'b1;
        end
        check("no_done_after_rst", 32'(seen_done), 0);
        check("idle_after_rst", 32'(busy), 0);

        // bank back at reset values: rates 0001 and potentials zero
        upd_we = 1'b1; upd_addr = '0; upd_potential = 32'h41DED852;
        tick();
        upd_addr = AW'(1);
        tick();
        upd_we = 1'b0;
        push(0, 32'h41DED852); push(1, 32'h41DED852); push(2, 32'h00000000); push(3, 32'h00000000);
        sweep_ready("s5");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
